id_ex_reg: RTL
==============

Name: id_ex_reg

Overview:
- ID/EX pipeline register that sits directly downstream of the instruction decoder.
- Each cycle it latches the decoder's control bundle (RegWrite, MemToReg, MemRead, MemWrite, Branch, RegDst, ALUOp, ALUSrc) together with the decode-stage operands, and presents them to the execute stage.
- Contains load-use hazard detection: it inserts a bubble and requests an upstream stall.
- Supports a flush for taken branches/jumps and a hold for downstream back-pressure.

Parameters:
- DATA_W, 32, datapath width for register data, immediate and PC.
- REG_ADDR_W, 5, register specifier width.
- CNT_W, 16, width of the load-use bubble counter.

Ports:
- clk  in  1  rising-edge clock, single clock domain.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  squash: the next ID/EX contents become a bubble.
- hold  in  1  downstream stall: freeze all ID/EX contents.
- id_valid  in  1  decode stage holds a real instruction.
- id_reg_write, id_mem_to_reg, id_mem_read, id_mem_write, id_branch, id_reg_dst, id_alu_src  in  1 each  decoder control outputs.
- id_alu_op  in  4  decoder ALUOp.
- id_rs_data, id_rt_data  in  DATA_W  register-file read data.
- id_imm  in  DATA_W  sign-extended immediate.
- id_pc_plus4  in  DATA_W  PC+4 of the decode instruction.
- id_shamt  in  5  shift amount.
- id_rs, id_rt, id_rd  in  REG_ADDR_W  register specifiers.
- ex_valid  out  1  execute stage holds a real instruction.
- ex_reg_write, ex_mem_to_reg, ex_mem_read, ex_mem_write, ex_branch, ex_reg_dst, ex_alu_src  out  1 each  registered control.
- ex_alu_op  out  4  registered ALUOp.
- ex_rs_data, ex_rt_data, ex_imm, ex_pc_plus4  out  DATA_W  registered operands.
- ex_shamt  out  5  registered shift amount.
- ex_rs, ex_rt, ex_rd  out  REG_ADDR_W  registered specifiers.
- stall_req  out  1  combinational; upstream PC and IF/ID must hold this cycle.
- bubble_count  out  CNT_W  saturating count of load-use bubbles inserted.

Behaviour:
- Reset (async, rst=1): every ex_* output = 0, ex_valid = 0, bubble_count = 0, stall_req = 0. Takes effect immediately and overrides a clock edge.
- Latency: exactly one cycle from id_* to ex_* when no hold, flush or hazard is present.
- Operand-use decode (combinational on id_*):
  - uses_rs = id_valid & ~(id_alu_op ∈ {0111, 1000, 1001}); shifts read rt and shamt only.
  - uses_rt = id_valid & (~id_alu_src | id_mem_write | id_branch).
- Load-use detection (combinational, from current ex_* registers):
  - load_use = ex_valid & ex_mem_read & (ex_rt != 0) & ((uses_rs & ex_rt == id_rs) | (uses_rt & ex_rt == id_rt)).
- stall_req = load_use & ~flush & ~rst.
- Posedge update, priority order:
  1. flush: bubble.
  2. hold: all ex_* and ex_valid retain their values.
  3. load_use: bubble.
  4. capture: ex_valid = id_valid and all data fields load from id_*. If id_valid = 0, all control outputs load 0.
- Bubble definition: ex_valid = 0, all control outputs = 0, ex_alu_op = 0000, all data and specifier outputs = 0.
- hold with load_use: hold wins and the register freezes. stall_req remains asserted and bubble_count does not increment.
- flush with load_use: flush wins, stall_req = 0, bubble_count does not increment.
- bubble_count: +1 only on edges where priority 3 is taken. Saturates at all-ones with no wrap.
- Register specifier 0 never causes a hazard.
- A bubble in EX (ex_valid = 0) never causes a hazard, so a single lw stalls exactly one cycle.

Test Plan:
- Reset mid-operation: load id_alu_op=0001, id_reg_write=1, id_rs_data=0x12345678; assert rst between clock edges -> all ex_* = 0 immediately, bubble_count = 0.
- Pass-through: id_valid=1, ADD controls (reg_write=1, alu_op=0001), rs=3, rt=4, rd=5, data 0xA/0xB -> next cycle ex_* match the inputs, ex_valid=1, stall_req=0.
- Load-use: EX holds lw (mem_read=1, ex_rt=8); ID holds an R-type with id_rs=8 -> stall_req=1; next edge ex_valid=0, controls 0, bubble_count=1; following cycle stall_req=0 and the R-type captures.
- No false hazard: ex_rt=0 with mem_read=1 matching id_rs=0 -> stall_req=0. Shift op (alu_op=1000) with id_rs=8 against ex_rt=8 -> stall_req=0.
- Flush priority: flush=1 together with load_use and hold -> stall_req=0; next edge produces a bubble; bubble_count unchanged.
- Hold and saturation:
  - hold=1 for 3 cycles while id_* change -> ex_* frozen.
  - With bubble_count forced via 65535 load-use events -> count stays at 0xFFFF on the next event.

Source files
------------

// File: rtl/id_ex_reg.sv
// -----------------------------------------------------------------------------
// id_ex_reg
//
// Pipeline register between instruction decode (ID) and execute (EX).
//
// Every clock edge it latches the decoder's control bundle and the decode-stage
// operands and presents them to EX. It also detects the classic load-use
// hazard: a load in EX whose destination (rt) is a source of the instruction
// now in ID. When that happens, a bubble is clocked into EX, and stall_req asks
// the PC and IF/ID registers to hold so that the dependent instruction is
// presented again on the next cycle.
//
// The update priority on each rising edge is:
//   flush > hold > load-use bubble > normal capture
//
// Ports
//   clk, rst           rising-edge clock; asynchronous active-high reset
//   flush              squash: next EX contents become a bubble
//   hold               downstream back-pressure: freeze all EX contents
//   id_valid           ID holds a real instruction
//   id_* control       reg_write, mem_to_reg, mem_read, mem_write, branch,
//                      reg_dst, alu_src (1 bit each), alu_op (4 bits)
//   id_* operands      rs_data, rt_data, imm, pc_plus4 (DATA_W), shamt (5),
//                      rs, rt, rd (REG_ADDR_W)
//   ex_*               registered copies of all of the above, plus ex_valid
//   stall_req          combinational: upstream PC and IF/ID must hold
//   bubble_count       saturating count of load-use bubbles inserted
// -----------------------------------------------------------------------------
module id_ex_reg #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  hold,

  // Decode stage
  input  logic                  id_valid,
  input  logic                  id_reg_write,
  input  logic                  id_mem_to_reg,
  input  logic                  id_mem_read,
  input  logic                  id_mem_write,
  input  logic                  id_branch,
  input  logic                  id_reg_dst,
  input  logic                  id_alu_src,
  input  logic [3:0]            id_alu_op,
  input  logic [DATA_W-1:0]     id_rs_data,
  input  logic [DATA_W-1:0]     id_rt_data,
  input  logic [DATA_W-1:0]     id_imm,
  input  logic [DATA_W-1:0]     id_pc_plus4,
  input  logic [4:0]            id_shamt,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic [REG_ADDR_W-1:0] id_rd,

  // Execute stage
  output logic                  ex_valid,
  output logic                  ex_reg_write,
  output logic                  ex_mem_to_reg,
  output logic                  ex_mem_read,
  output logic                  ex_mem_write,
  output logic                  ex_branch,
  output logic                  ex_reg_dst,
  output logic                  ex_alu_src,
  output logic [3:0]            ex_alu_op,
  output logic [DATA_W-1:0]     ex_rs_data,
  output logic [DATA_W-1:0]     ex_rt_data,
  output logic [DATA_W-1:0]     ex_imm,
  output logic [DATA_W-1:0]     ex_pc_plus4,
  output logic [4:0]            ex_shamt,
  output logic [REG_ADDR_W-1:0] ex_rs,
  output logic [REG_ADDR_W-1:0] ex_rt,
  output logic [REG_ADDR_W-1:0] ex_rd,

  // Hazard interface
  output logic                  stall_req,
  output logic [CNT_W-1:0]      bubble_count
);

  // ALUOp codes of the shift operations. Shifts take their operand from rt and
  // the shift amount from shamt, so the rs field is not a real source for them.
  localparam logic [3:0] ALU_OP_SHIFT_A = 4'b0111;
  localparam logic [3:0] ALU_OP_SHIFT_B = 4'b1000;
  localparam logic [3:0] ALU_OP_SHIFT_C = 4'b1001;

  // Everything that travels from ID to EX. All-zero is exactly a bubble.
  typedef struct packed {
    logic                  valid;
    logic                  reg_write;
    logic                  mem_to_reg;
    logic                  mem_read;
    logic                  mem_write;
    logic                  branch;
    logic                  reg_dst;
    logic                  alu_src;
    logic [3:0]            alu_op;
    logic [DATA_W-1:0]     rs_data;
    logic [DATA_W-1:0]     rt_data;
    logic [DATA_W-1:0]     imm;
    logic [DATA_W-1:0]     pc_plus4;
    logic [4:0]            shamt;
    logic [REG_ADDR_W-1:0] rs;
    logic [REG_ADDR_W-1:0] rt;
    logic [REG_ADDR_W-1:0] rd;
  } stage_t;

  localparam stage_t BUBBLE = '0;

  stage_t ex_q;       // current EX contents
  stage_t ex_d;       // contents to load on the next edge
  stage_t id_stage;   // decode-stage bundle as it would be captured

  logic   uses_rs;
  logic   uses_rt;
  logic   is_shift;
  logic   rs_match;
  logic   rt_match;
  logic   load_use;
  logic   insert_bubble;

  logic [CNT_W-1:0] bubble_cnt_q;

  // ---------------------------------------------------------------------------
  // Capture view of the decode stage. Data fields always follow id_*; the
  // control bundle (including ALUOp) is forced to zero for an empty slot so
  // that an invalid decode slot can never write state downstream.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable driven from always_comb gets a full default first,
    // so no path through the block can leave it unassigned and infer a latch.
    id_stage          = BUBBLE;
    id_stage.valid    = id_valid;
    id_stage.rs_data  = id_rs_data;
    id_stage.rt_data  = id_rt_data;
    id_stage.imm      = id_imm;
    id_stage.pc_plus4 = id_pc_plus4;
    id_stage.shamt    = id_shamt;
    id_stage.rs       = id_rs;
    id_stage.rt       = id_rt;
    id_stage.rd       = id_rd;
    if (id_valid) begin
      id_stage.reg_write  = id_reg_write;
      id_stage.mem_to_reg = id_mem_to_reg;
      id_stage.mem_read   = id_mem_read;
      id_stage.mem_write  = id_mem_write;
      id_stage.branch     = id_branch;
      id_stage.reg_dst    = id_reg_dst;
      id_stage.alu_src    = id_alu_src;
      id_stage.alu_op     = id_alu_op;
    end
  end

  // ---------------------------------------------------------------------------
  // Operand-use decode: which register fields the ID instruction really reads.
  // rt is a source when the ALU's second operand is a register (alu_src = 0),
  // and also for stores (store data) and branches (compare operand), even
  // though those select the immediate for the ALU.
  // ---------------------------------------------------------------------------
  assign is_shift = (id_alu_op == ALU_OP_SHIFT_A) ||
                    (id_alu_op == ALU_OP_SHIFT_B) ||
                    (id_alu_op == ALU_OP_SHIFT_C);

  assign uses_rs = id_valid & ~is_shift;
  assign uses_rt = id_valid & (~id_alu_src | id_mem_write | id_branch);

  // ---------------------------------------------------------------------------
  // Load-use detection against the load currently in EX. Register 0 is
  // hard-wired to zero and never carries a dependence. A bubble in EX has
  // ex_valid = 0, so the cycle after a bubble is inserted is hazard-free and a
  // single load stalls for exactly one cycle.
  // ---------------------------------------------------------------------------
  assign rs_match = uses_rs & (ex_q.rt == id_rs);
  assign rt_match = uses_rt & (ex_q.rt == id_rt);

  assign load_use = ex_q.valid & ex_q.mem_read & (ex_q.rt != '0) &
                    (rs_match | rt_match);

  // A flush squashes the dependent instruction anyway, so no stall is needed.
  // Under hold the request stays up: the frozen load is still in EX.
  assign stall_req = load_use & ~flush & ~rst;

  // The bubble is counted only when it is really clocked in.
  assign insert_bubble = load_use & ~flush & ~hold;

  // ---------------------------------------------------------------------------
  // Next-state selection in priority order.
  // ---------------------------------------------------------------------------
  always_comb begin
    ex_d = ex_q;
    if (flush) begin
      ex_d = BUBBLE;
    end else if (hold) begin
      ex_d = ex_q;
    end else if (load_use) begin
      ex_d = BUBBLE;
    end else begin
      ex_d = id_stage;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs from before the edge, independent of block order.
    if (rst) begin
      ex_q <= BUBBLE;
    end else begin
      ex_q <= ex_d;
    end
  end

  // Saturating bubble counter: sticks at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bubble_cnt_q <= '0;
    end else if (insert_bubble && (bubble_cnt_q != '1)) begin
      bubble_cnt_q <= bubble_cnt_q + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs.
  // ---------------------------------------------------------------------------
  assign ex_valid      = ex_q.valid;
  assign ex_reg_write  = ex_q.reg_write;
  assign ex_mem_to_reg = ex_q.mem_to_reg;
  assign ex_mem_read   = ex_q.mem_read;
  assign ex_mem_write  = ex_q.mem_write;
  assign ex_branch     = ex_q.branch;
  assign ex_reg_dst    = ex_q.reg_dst;
  assign ex_alu_src    = ex_q.alu_src;
  assign ex_alu_op     = ex_q.alu_op;
  assign ex_rs_data    = ex_q.rs_data;
  assign ex_rt_data    = ex_q.rt_data;
  assign ex_imm        = ex_q.imm;
  assign ex_pc_plus4   = ex_q.pc_plus4;
  assign ex_shamt      = ex_q.shamt;
  assign ex_rs         = ex_q.rs;
  assign ex_rt         = ex_q.rt;
  assign ex_rd         = ex_q.rd;

  assign bubble_count  = bubble_cnt_q;

endmodule
